wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the three execution units: Mult, AluMisc and Mem.
- Each unit pushes completed results into its own small queue through a valid/ready handshake.
- Each cycle the arbiter selects one queue head and drives a registered, one-cycle write to the register file.
- Replaces direct unit-to-writeback wiring, so simultaneous completions stall the producer instead of being lost.

---
 rtl/wb_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between Mult, AluMisc and Mem through per-source queues; fixed priority mem > am > mul, WB_STARVE_GUARD_EN adds anti-starvation.
// Latency: an accepted entry is written one edge after acceptance when its queue wins; one write per cycle.
// Backpressure: x_ready drops only when that source's queue is full; ready never depends on x_valid.

module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= push_dat;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_dat = mem_q[rd_ptr];
endmodule

module wb_port_arbiter #(
  parameter int DEPTH = 2
`ifdef WB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mul_valid,
  input  logic [4:0]  mul_regdest,
  input  logic [31:0] mul_wbvalue,
  output logic        mul_ready,
  input  logic        am_valid,
  input  logic [4:0]  am_regdest,
  input  logic [31:0] am_wbvalue,
  output logic        am_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_regdest,
  input  logic [31:0] mem_wbvalue,
  output logic        mem_ready,
  output logic        wb_reg_en,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_reg_data,
  output logic        wb_busy
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  regdest;
    logic [31:0] wbvalue;
  } wb_entry_t;

  localparam int EW = $bits(wb_entry_t);

  // Source index: 0 = mul, 1 = am, 2 = mem.
  logic [2:0]    src_vld;
  logic [2:0]    src_rdy;
  logic [2:0]    push_vld;
  logic [2:0]    nonempty;
  logic [2:0]    grant;
  wb_entry_t     src_dat  [3];
  wb_entry_t     head_dat [3];
  logic [CW-1:0] cnt      [3];
  wb_entry_t     win_dat;

  assign src_vld    = {mem_valid, am_valid, mul_valid};
  assign src_dat[0] = {mul_regdest, mul_wbvalue};
  assign src_dat[1] = {am_regdest, am_wbvalue};
  assign src_dat[2] = {mem_regdest, mem_wbvalue};

  for (genvar i = 0; i < 3; i++) begin : g_q
    assign src_rdy[i]  = (cnt[i] != FULL);
    assign nonempty[i] = (cnt[i] != '0);
    // Writes to r0 complete the handshake but are dropped here.
    assign push_vld[i] = src_vld[i] && src_rdy[i] && (src_dat[i].regdest != 5'd0);

    wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push_vld[i]),
      .push_dat (src_dat[i]),
      .pop      (grant[i]),
      .head_dat (head_dat[i]),
      .count    (cnt[i])
    );
  end

  assign mul_ready = src_rdy[0];
  assign am_ready  = src_rdy[1];
  assign mem_ready = src_rdy[2];
  assign wb_busy   = |nonempty;

`ifdef WB_STARVE_GUARD_EN
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

  logic [WW-1:0] wait_cnt [3];
  logic [2:0]    starved;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!nonempty[i] || grant[i]) wait_cnt[i] <= '0;
        else if (wait_cnt[i] != LIMIT) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    starved = '0;
    for (int i = 0; i < 3; i++) starved[i] = nonempty[i] && (wait_cnt[i] == LIMIT);
  end
`endif

  always_comb begin
    grant = '0;
    if (nonempty[2])      grant = 3'b100;
    else if (nonempty[1]) grant = 3'b010;
    else if (nonempty[0]) grant = 3'b001;
`ifdef WB_STARVE_GUARD_EN
    // Starved sources override, resolved in the reverse order mul > am > mem.
    if (starved[0])      grant = 3'b001;
    else if (starved[1]) grant = 3'b010;
    else if (starved[2]) grant = 3'b100;
`endif
  end

  always_comb begin
    win_dat = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) win_dat = head_dat[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_reg_en   <= 1'b0;
      wb_reg_addr <= '0;
      wb_reg_data <= '0;
    end else begin
      wb_reg_en   <= |grant;
      wb_reg_addr <= win_dat.regdest;
      wb_reg_data <= win_dat.wbvalue;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: priority, latency, backpressure, r0 drop, reset and starvation guard.
`timescale 1ns/1ps

module tb_wb_port_arbiter;
  logic        clock;
  logic        reset;
  logic        mul_valid, am_valid, mem_valid;
  logic [4:0]  mul_regdest, am_regdest, mem_regdest;
  logic [31:0] mul_wbvalue, am_wbvalue, mem_wbvalue;
  logic        mul_ready, am_ready, mem_ready;
  logic        wb_reg_en;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_reg_data;
  logic        wb_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  log_addr [16];
  logic [31:0] log_data [16];
  int          log_cyc  [16];
  int          nlog;

  wb_port_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .mul_valid   (mul_valid),
    .mul_regdest (mul_regdest),
    .mul_wbvalue (mul_wbvalue),
    .mul_ready   (mul_ready),
    .am_valid    (am_valid),
    .am_regdest  (am_regdest),
    .am_wbvalue  (am_wbvalue),
    .am_ready    (am_ready),
    .mem_valid   (mem_valid),
    .mem_regdest (mem_regdest),
    .mem_wbvalue (mem_wbvalue),
    .mem_ready   (mem_ready),
    .wb_reg_en   (wb_reg_en),
    .wb_reg_addr (wb_reg_addr),
    .wb_reg_data (wb_reg_data),
    .wb_busy     (wb_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    mul_valid = 1'b0; mul_regdest = '0; mul_wbvalue = '0;
    am_valid  = 1'b0; am_regdest  = '0; am_wbvalue  = '0;
    mem_valid = 1'b0; mem_regdest = '0; mem_wbvalue = '0;
  endtask

  task automatic log_write(input int c);
    if (wb_reg_en && nlog < 16) begin
      log_addr[nlog] = wb_reg_addr;
      log_data[nlog] = wb_reg_data;
      log_cyc[nlog]  = c;
      nlog++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    tick(); tick();
    n_checks++; if (wb_reg_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", wb_reg_en); end
    n_checks++; if (wb_reg_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", wb_reg_addr); end
    n_checks++; if (wb_reg_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", wb_reg_data); end
    n_checks++; if (wb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", wb_busy); end
    n_checks++; if ({mem_ready, am_ready, mul_ready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready got %b want 111", {mem_ready, am_ready, mul_ready});
    end
    reset = 1'b1;
    tick();
    n_checks++; if (wb_reg_en !== 1'b0) begin n_fail++; $display("FAIL release_en got %b want 0", wb_reg_en); end
  endtask

  task automatic test_single;
    mul_valid = 1'b1; mul_regdest = 5'd3; mul_wbvalue = 32'h0000_00AA;
    tick();
    idle_inputs();
    n_checks++; if (wb_reg_en !== 1'b0) begin n_fail++; $display("FAIL single_early_en got %b want 0", wb_reg_en); end
    n_checks++; if (wb_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", wb_busy); end
    tick();
    n_checks++; if (wb_reg_en !== 1'b1) begin n_fail++; $display("FAIL single_en got %b want 1", wb_reg_en); end
    n_checks++; if (wb_reg_addr !== 5'd3) begin n_fail++; $display("FAIL single_addr got %0d want 3", wb_reg_addr); end
    n_checks++; if (wb_reg_data !== 32'hAA) begin n_fail++; $display("FAIL single_data got %h want aa", wb_reg_data); end
    n_checks++; if (wb_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %b want 0", wb_busy); end
    tick();
    n_checks++; if (wb_reg_en !== 1'b0) begin n_fail++; $display("FAIL single_en_after got %b want 0", wb_reg_en); end
    n_checks++; if (wb_reg_addr !== 5'd0 || wb_reg_data !== 32'd0) begin
      n_fail++; $display("FAIL single_idle_out got %0d/%h want 0/0", wb_reg_addr, wb_reg_data);
    end
  endtask

  task automatic test_simultaneous;
    logic [4:0]  ea [4];
    logic [31:0] ed [4];
    logic        ee [4];
    ea = '{5'd5, 5'd6, 5'd7, 5'd0};
    ed = '{32'h55, 32'h66, 32'h77, 32'h0};
    ee = '{1'b1, 1'b1, 1'b1, 1'b0};
    mem_valid = 1'b1; mem_regdest = 5'd5; mem_wbvalue = 32'h55;
    am_valid  = 1'b1; am_regdest  = 5'd6; am_wbvalue  = 32'h66;
    mul_valid = 1'b1; mul_regdest = 5'd7; mul_wbvalue = 32'h77;
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (wb_reg_en !== ee[c] || wb_reg_addr !== ea[c] || wb_reg_data !== ed[c]) begin
        n_fail++;
        $display("FAIL simul_%0d got en=%b a=%0d d=%h want en=%b a=%0d d=%h",
                 c, wb_reg_en, wb_reg_addr, wb_reg_data, ee[c], ea[c], ed[c]);
      end
    end
    n_checks++; if (wb_busy !== 1'b0) begin n_fail++; $display("FAIL simul_busy got %b want 0", wb_busy); end
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    for (int c = 0; c < 6; c++) begin
      mul_valid   = (sent < 4);
      mul_regdest = 5'(sent + 1);
      mul_wbvalue = 32'(32'hC00 + sent + 1);
      tick();
      if (mul_valid) sent++;
      if (c >= 1 && c <= 4) begin
        n_checks++; if (wb_reg_en !== 1'b1 || wb_reg_addr !== 5'(c) || wb_reg_data !== 32'(32'hC00 + c)) begin
          n_fail++;
          $display("FAIL b2b_%0d got en=%b a=%0d d=%h want en=1 a=%0d d=%h",
                   c, wb_reg_en, wb_reg_addr, wb_reg_data, c, 32'hC00 + c);
        end
      end else if (c == 5) begin
        n_checks++; if (wb_reg_en !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", wb_reg_en); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_starvation;
    int mem_sent = 0;
    int exp_a [9];
    logic acc;
`ifdef WB_STARVE_GUARD_EN
    exp_a = '{1, 2, 3, 4, 9, 5, 6, 7, 8};
`else
    exp_a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
`endif
    nlog = 0;
    for (int c = 0; c < 12; c++) begin
      am_valid    = (c == 0);
      am_regdest  = 5'd9;
      am_wbvalue  = 32'h999;
      mem_valid   = (mem_sent < 8);
      mem_regdest = 5'(mem_sent + 1);
      mem_wbvalue = 32'(32'h100 + mem_sent + 1);
      acc = mem_valid && mem_ready;
      tick();
      if (acc) mem_sent++;
      log_write(c);
    end
    idle_inputs();
    n_checks++; if (mem_sent != 8) begin n_fail++; $display("FAIL starve_mem_sent got %0d want 8", mem_sent); end
    n_checks++; if (nlog != 9) begin n_fail++; $display("FAIL starve_nwrites got %0d want 9", nlog); end
    for (int i = 0; i < 9; i++) begin
      if (i < nlog) begin
        n_checks++;
        if (log_addr[i] !== 5'(exp_a[i]) || log_cyc[i] != i + 1 ||
            log_data[i] !== ((exp_a[i] == 9) ? 32'h999 : 32'(32'h100 + exp_a[i]))) begin
          n_fail++;
          $display("FAIL starve_w%0d got a=%0d d=%h cyc=%0d want a=%0d cyc=%0d",
                   i, log_addr[i], log_data[i], log_cyc[i], exp_a[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int am_sent = 0;
    int mem_sent = 0;
    int exp_a [7];
    logic am_acc, mem_acc, exp_rdy;
    exp_a = '{20, 21, 22, 23, 10, 11, 12};
    nlog = 0;
    for (int c = 0; c < 10; c++) begin
      am_valid    = (am_sent < 3);
      am_regdest  = 5'(10 + am_sent);
      am_wbvalue  = 32'(32'hA00 + 10 + am_sent);
      mem_valid   = (mem_sent < 4);
      mem_regdest = 5'(20 + mem_sent);
      mem_wbvalue = 32'(32'hB00 + 20 + mem_sent);
      am_acc  = am_valid && am_ready;
      mem_acc = mem_valid && mem_ready;
      tick();
      if (am_acc) am_sent++;
      if (mem_acc) mem_sent++;
      log_write(c);
      exp_rdy = !(c >= 1 && c <= 4);
      n_checks++; if (am_ready !== exp_rdy) begin
        n_fail++; $display("FAIL bp_am_ready_c%0d got %b want %b", c, am_ready, exp_rdy);
      end
    end
    idle_inputs();
    n_checks++; if (am_sent != 3 || mem_sent != 4) begin
      n_fail++; $display("FAIL bp_accepts got am=%0d mem=%0d want am=3 mem=4", am_sent, mem_sent);
    end
    n_checks++; if (nlog != 7) begin n_fail++; $display("FAIL bp_nwrites got %0d want 7", nlog); end
    for (int i = 0; i < 7; i++) begin
      if (i < nlog) begin
        n_checks++;
        if (log_addr[i] !== 5'(exp_a[i]) || log_cyc[i] != i + 1 ||
            log_data[i] !== ((exp_a[i] < 20) ? 32'(32'hA00 + exp_a[i]) : 32'(32'hB00 + exp_a[i]))) begin
          n_fail++;
          $display("FAIL bp_w%0d got a=%0d d=%h cyc=%0d want a=%0d cyc=%0d",
                   i, log_addr[i], log_data[i], log_cyc[i], exp_a[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_regdest_zero;
    mul_valid = 1'b1; mul_regdest = 5'd0; mul_wbvalue = 32'hDEAD;
    n_checks++; if (mul_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready_before got %b want 1", mul_ready); end
    tick();
    idle_inputs();
    n_checks++; if (mul_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready_after got %b want 1", mul_ready); end
    n_checks++; if (wb_busy !== 1'b0) begin n_fail++; $display("FAIL r0_busy got %b want 0", wb_busy); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (wb_reg_en !== 1'b0 || wb_busy !== 1'b0) begin
        n_fail++; $display("FAIL r0_nowrite_%0d got en=%b busy=%b want 0/0", c, wb_reg_en, wb_busy);
      end
    end
  endtask

  task automatic test_reset_mid;
    mul_valid = 1'b1; mul_regdest = 5'd14; mul_wbvalue = 32'hE0E;
    am_valid  = 1'b1; am_regdest  = 5'd13; am_wbvalue  = 32'hD0D;
    tick();
    idle_inputs();
    n_checks++; if (wb_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got %b want 1", wb_busy); end
    tick();
    n_checks++; if (wb_reg_en !== 1'b1 || wb_reg_addr !== 5'd13) begin
      n_fail++; $display("FAIL rmid_first got en=%b a=%0d want en=1 a=13", wb_reg_en, wb_reg_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (wb_reg_en !== 1'b0 || wb_reg_addr !== 5'd0 || wb_reg_data !== 32'd0) begin
      n_fail++; $display("FAIL rmid_out got en=%b a=%0d d=%h want 0/0/0", wb_reg_en, wb_reg_addr, wb_reg_data);
    end
    n_checks++; if (wb_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_clr got %b want 0", wb_busy); end
    n_checks++; if ({mem_ready, am_ready, mul_ready} !== 3'b111) begin
      n_fail++; $display("FAIL rmid_ready got %b want 111", {mem_ready, am_ready, mul_ready});
    end
    tick(); tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (wb_reg_en !== 1'b0 || wb_busy !== 1'b0 || {mem_ready, am_ready, mul_ready} !== 3'b111) begin
        n_fail++;
        $display("FAIL rmid_post_%0d got en=%b busy=%b rdy=%b want 0/0/111",
                 c, wb_reg_en, wb_busy, {mem_ready, am_ready, mul_ready});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_starvation();
    test_backpressure();
    test_regdest_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
